// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode: instruction decode and operand-fetch stage, upstream of the ALU.
//
// Owns the 32x32 integer register file. When the pipeline stage counter
// reaches 2 it decodes the instruction word, reads rs1/rs2, builds the
// immediate, registers operand A, operand B and the pass-through value, and
// then raises one-cycle load strobes so the ALU can latch them.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   stage_i[2:0]      global pipeline stage counter (decode runs in stage 2)
//   ir_i[31:0]        instruction word, stable while stage_i == 2
//   wb_en_i           register-file write enable from write-back
//   wb_rd_i[4:0]      write destination index (x0 writes are dropped)
//   wb_data_i[31:0]   write data
//   readd_a_o         operand A to the ALU
//   readd_b_o         operand B to the ALU
//   readd_pass_o      pass-through value to the ALU (store data)
//   readin_a_o / readin_b_o / readin_pass_o
//                     one-cycle load strobes, high only in STROBE
//   itype_o[4:0]      instruction type code, 0 for an illegal opcode
//   illegal_o         one-cycle pulse for an unrecognised opcode
//   busy_o            high whenever the FSM is not IDLE
//
// Handshake: there is no back-pressure. Each stage-2 entry produces exactly
// one decode; data and strobes are registered on the same edge, the strobes
// stay high for one cycle and the data holds until the next decode.
//
// Build option: define DECODE_WB_BYPASS_EN to forward a same-cycle
// write-back into the operands read during FETCH.
// ---------------------------------------------------------------------------
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  stage_i,
    input  logic [31:0] ir_i,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] readd_a_o,
    output logic [31:0] readd_b_o,
    output logic [31:0] readd_pass_o,
    output logic        readin_a_o,
    output logic        readin_b_o,
    output logic        readin_pass_o,
    output logic [4:0]  itype_o,
    output logic        illegal_o,
    output logic        busy_o
);

    // Shared one-hot instruction-type codes (bit 3 is reserved for B-type).
    localparam logic [4:0] RTYPE = 5'b00001;
    localparam logic [4:0] ITYPE = 5'b00010;
    localparam logic [4:0] STYPE = 5'b00100;
    localparam logic [4:0] UTYPE = 5'b10000;

    typedef enum logic [1:0] {IDLE, FETCH, STROBE} state_t;

    state_t      state, state_nxt;
    logic        armed, armed_nxt;
    logic [31:0] regs [32];

    logic [31:0] a_nxt, b_nxt, pass_nxt;
    logic [4:0]  itype_nxt;
    logic        illegal_nxt, sa_nxt, sb_nxt, sp_nxt;

    // Register file: write-back has the array to itself, x0 stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en_i && (wb_rd_i != 5'd0)) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_val, rs2_val;

    assign opcode = ir_i[6:0];
    assign rs1    = ir_i[19:15];
    assign rs2    = ir_i[24:20];

    always_comb begin
        rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
        rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
`ifdef DECODE_WB_BYPASS_EN
        // Forward the value being written this edge so FETCH sees it now.
        if (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1)) rs1_val = wb_data_i;
        if (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2)) rs2_val = wb_data_i;
`endif
    end

    // Opcode classification and operand selection.
    logic        dec_legal, dec_spass;
    logic [4:0]  dec_itype;
    logic [31:0] dec_a, dec_b, dec_pass;

    always_comb begin
        dec_legal = 1'b1;
        dec_spass = 1'b0;
        dec_itype = 5'd0;
        dec_a     = 32'd0;
        dec_b     = 32'd0;
        dec_pass  = 32'd0;
        case (opcode)
            7'b0110011: begin
                dec_itype = RTYPE;
                dec_a     = rs1_val;
                dec_b     = rs2_val;
            end
            7'b0010011, 7'b0000011: begin
                dec_itype = ITYPE;
                dec_a     = rs1_val;
                dec_b     = {{20{ir_i[31]}}, ir_i[31:20]};
            end
            7'b0100011: begin
                dec_itype = STYPE;
                dec_a     = rs1_val;
                dec_b     = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
                dec_pass  = rs2_val;
                dec_spass = 1'b1;
            end
            7'b0110111: begin
                dec_itype = UTYPE;
                dec_b     = {ir_i[31:12], 12'b0};
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // FSM state, armed flag and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            armed         <= 1'b1;
            readd_a_o     <= '0;
            readd_b_o     <= '0;
            readd_pass_o  <= '0;
            readin_a_o    <= 1'b0;
            readin_b_o    <= 1'b0;
            readin_pass_o <= 1'b0;
            itype_o       <= '0;
            illegal_o     <= 1'b0;
        end else begin
            state         <= state_nxt;
            armed         <= armed_nxt;
            readd_a_o     <= a_nxt;
            readd_b_o     <= b_nxt;
            readd_pass_o  <= pass_nxt;
            readin_a_o    <= sa_nxt;
            readin_b_o    <= sb_nxt;
            readin_pass_o <= sp_nxt;
            itype_o       <= itype_nxt;
            illegal_o     <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        armed_nxt   = armed;
        a_nxt       = readd_a_o;
        b_nxt       = readd_b_o;
        pass_nxt    = readd_pass_o;
        itype_nxt   = itype_o;
        illegal_nxt = 1'b0;
        sa_nxt      = 1'b0;
        sb_nxt      = 1'b0;
        sp_nxt      = 1'b0;

        // Leaving stage 2 re-arms, so a long stage 2 decodes only once.
        if (stage_i != 3'd2) armed_nxt = 1'b1;

        case (state)
            IDLE: begin
                if ((stage_i == 3'd2) && armed) begin
                    armed_nxt = 1'b0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (dec_legal) begin
                    a_nxt     = dec_a;
                    b_nxt     = dec_b;
                    pass_nxt  = dec_pass;
                    itype_nxt = dec_itype;
                    // Strobe registers rise together with the entry to STROBE.
                    sa_nxt    = 1'b1;
                    sb_nxt    = 1'b1;
                    sp_nxt    = dec_spass;
                    state_nxt = STROBE;
                end else begin
                    itype_nxt   = 5'd0;
                    illegal_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            STROBE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);

endmodule
